free_list: RTL and testbench
============================

# free_list

Physical-register free list for the rename stage, upstream of the physical register file. Each cycle it supplies up to two free physical register tags to rename. Those tags are the registers rename then marks busy in the PRF. At retire it reclaims the superseded physical register. On flush it rolls back all speculative allocations in one cycle using a committed head pointer.

## Interface
- PHY_REGS, 64: number of physical registers.
- ARCH_REGS, 32: number of architectural registers. Physical 0..ARCH_REGS-1 hold the reset mapping.
- PHY_WIDTH, 6: physical tag width, clog2(PHY_REGS).
- FREE_DEPTH, PHY_REGS-ARCH_REGS (32): free-list capacity.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  squash all uncommitted allocations.
- alloc_req  in  2  bit k set = rename slot k needs a destination tag.
- alloc_grant  out  1  request satisfiable. Allocation happens only when high.
- alloc_phy_0  out  PHY_WIDTH  tag for slot 0.
- alloc_phy_1  out  PHY_WIDTH  tag for slot 1.
- free_count  out  clog2(FREE_DEPTH)+1  registered number of free entries.
- retire_valid  in  1  an instruction retires this cycle.
- retire_has_rd  in  1  the retiring instruction wrote a renamed rd.
- rd_phy_old_commit  in  PHY_WIDTH  previous mapping of the retiring rd, to be freed.
- overflow_err  out  1  sticky. Set when a free arrives while the list is full.

## Operation
- Storage: circular array fl[0..FREE_DEPTH-1] of PHY_WIDTH tags.
- Pointers: head, tail and commit_head are clog2(FREE_DEPTH)+1 bits wide. The extra MSB is a wrap bit. Indexing uses the low bits.
- free_count = tail - head, modulo 2^(ptr width).
- Reset values:
  - fl[i] = ARCH_REGS+i.
  - head = 0, commit_head = 0, tail = FREE_DEPTH.
  - free_count = FREE_DEPTH, overflow_err = 0.
- Outputs are combinational from state:
  - alloc_phy_0 = fl[head].
  - alloc_phy_1 = alloc_req[0] ? fl[head+1] : fl[head].
  - alloc_grant = !flush && free_count >= popcount(alloc_req). alloc_req = 0 gives grant = 1.
- Allocate: when alloc_grant and n = popcount(alloc_req) > 0, head += n. It is all-or-nothing: a partial grant never happens.
- Free: when retire_valid && retire_has_rd:
  - fl[tail] <= rd_phy_old_commit, tail += 1, commit_head += 1.
  - Retire is in order, so commit_head tracks the allocation belonging to the oldest live instruction.
  - retire_valid with !retire_has_rd changes nothing.
- Flush: head <= commit_head, which returns every speculative tag to the list. No allocation occurs that cycle. A free in the same cycle still completes: tail and commit_head advance, and head takes the advanced commit_head.
- Simultaneous allocate and free: both apply. free_count_next = free_count - n + 1.
- Full-list free: a free arriving when free_count == FREE_DEPTH is illegal. The write is dropped, pointers are unchanged, and overflow_err is set until rst.
- Physical register 0 (the x0 mapping) is never allocated or freed. Rename does not request a tag for rd = x0.

## Timing
- All state updates on the rising clk edge. rst overrides everything asynchronously.
- Tags requested in cycle t are valid combinationally in cycle t. head advances at the end of cycle t.
- A tag freed in cycle t is allocatable no earlier than cycle t+1 after wrap-around. alloc_grant uses registered free_count, so there is no same-cycle bypass.
- Flush takes effect in 1 cycle. The first post-flush allocation is in cycle t+1.
- Wrap: pointer low bits wrap modulo FREE_DEPTH. The wrap bit distinguishes full (count 32) from empty (count 0).

## Structure
- Shared parameter package holds:
  - FREE_DEPTH = PHY_REGS - ARCH_REGS.
  - FL_PTR_W = clog2(FREE_DEPTH) + 1.
- Shared typedef package holds phy_tag_t, a logic [PHY_WIDTH-1:0] tag type.
- Single module with no sub-module. The 2-bit popcount is inline.

## Test plan
- Reset, then alloc_req=2'b11 -> alloc_phy_0=32, alloc_phy_1=33, grant=1; next cycle free_count=30.
- 16 consecutive 2'b11 allocations -> tags 32..63 issued in order, free_count=0. Then alloc_req=2'b01 -> grant=0, head unchanged.
- From empty, retire_has_rd with old=5 -> free_count=1 next cycle. Then alloc_req=2'b11 -> grant=0. alloc_req=2'b10 -> grant=1, alloc_phy_1=5.
- Allocate 4 tags (32..35), then retire old=3, then flush -> free_count=32; next alloc_req=2'b11 gives 33,34.
- Same cycle alloc_req=2'b11 and free of old=7 from full -> overflow_err=1, free dropped, head +2, free_count=30.
- Assert rst mid-stream after 10 allocations -> next cycle alloc_phy_0=32, free_count=32, overflow_err=0.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizing parameters and tag/pointer types for the rename free list.
package free_list_pkg;
  localparam int PHY_REGS   = 64;
  localparam int ARCH_REGS  = 32;
  localparam int PHY_WIDTH  = $clog2(PHY_REGS);
  localparam int FREE_DEPTH = PHY_REGS - ARCH_REGS;
  localparam int FL_PTR_W   = $clog2(FREE_DEPTH) + 1;
  localparam int IDX_W      = FL_PTR_W - 1;

  typedef logic [PHY_WIDTH-1:0] phy_tag_t;
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;
  typedef logic [IDX_W-1:0]     fl_idx_t;
endpackage

// File: rtl/free_list_if.sv
// Rename/retire-side bundle of the free list; master is rename, slave is the list.
interface free_list_if;
  import free_list_pkg::*;

  logic       flush;
  logic [1:0] alloc_req;
  logic       alloc_grant;
  phy_tag_t   alloc_phy_0;
  phy_tag_t   alloc_phy_1;
  fl_ptr_t    free_count;
  logic       retire_valid;
  logic       retire_has_rd;
  phy_tag_t   rd_phy_old_commit;
  logic       overflow_err;

  modport master (
    output flush, alloc_req, retire_valid, retire_has_rd, rd_phy_old_commit,
    input  alloc_grant, alloc_phy_0, alloc_phy_1, free_count, overflow_err
  );

  modport slave (
    input  flush, alloc_req, retire_valid, retire_has_rd, rd_phy_old_commit,
    output alloc_grant, alloc_phy_0, alloc_phy_1, free_count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: two-wide allocate, in-order reclaim at retire,
// single-cycle flush rollback to the committed head.
module free_list
  import free_list_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  free_list_if.slave bus
);

  phy_tag_t   fl_q [FREE_DEPTH];
  fl_ptr_t    head_q, head_d;
  fl_ptr_t    tail_q, tail_d;
  fl_ptr_t    commit_q, commit_d;
  logic       ovf_q, ovf_d;

  fl_ptr_t    count;
  logic [1:0] n_req;
  logic       grant;
  logic       do_free;
  logic       full;
  logic       wr_en;
  fl_idx_t    head_idx;
  fl_idx_t    head1_idx;

  always_comb begin
    n_req     = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
    count     = tail_q - head_q;
    grant     = !bus.flush && (count >= fl_ptr_t'(n_req));
    do_free   = bus.retire_valid && bus.retire_has_rd;
    full      = (count == fl_ptr_t'(FREE_DEPTH));
    wr_en     = do_free && !full;
    head_idx  = head_q[IDX_W-1:0];
    head1_idx = head_idx + fl_idx_t'(1);

    tail_d   = tail_q;
    commit_d = commit_q;
    head_d   = head_q;
    ovf_d    = ovf_q;

    if (wr_en) begin
      tail_d   = tail_q + fl_ptr_t'(1);
      commit_d = commit_q + fl_ptr_t'(1);
    end
    if (do_free && full) ovf_d = 1'b1;

    // Flush rolls back to the committed head including this cycle's retire.
    if (bus.flush)  head_d = commit_d;
    else if (grant) head_d = head_q + fl_ptr_t'(n_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= fl_ptr_t'(FREE_DEPTH);
      ovf_q    <= 1'b0;
      for (int i = 0; i < FREE_DEPTH; i++) fl_q[i] <= phy_tag_t'(ARCH_REGS + i);
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      ovf_q    <= ovf_d;
      if (wr_en) fl_q[tail_q[IDX_W-1:0]] <= bus.rd_phy_old_commit;
    end
  end

  assign bus.alloc_grant  = grant;
  assign bus.alloc_phy_0  = fl_q[head_idx];
  assign bus.alloc_phy_1  = bus.alloc_req[0] ? fl_q[head1_idx] : fl_q[head_idx];
  assign bus.free_count   = count;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Directed scoreboard bench for free_list: expectations are queued at drive time
// and popped against the DUT outputs.
module tb_free_list;
  import free_list_pkg::*;

  logic clk;
  logic rst;
  free_list_if bus ();

  free_list dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] obs_of(string t);
    if (t == "phy0")       return 32'(bus.alloc_phy_0);
    else if (t == "phy1")  return 32'(bus.alloc_phy_1);
    else if (t == "grant") return 32'(bus.alloc_grant);
    else if (t == "count") return 32'(bus.free_count);
    else if (t == "ovf")   return 32'(bus.overflow_err);
    else                   return 32'hdead_beef;
  endfunction

  task automatic push(string t, int v);
    exp_t e;
    e.tag = t;
    e.val = 32'(v);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_of(e.tag);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic apply(logic f, logic [1:0] req, logic rv, logic rhr, int old);
    @(negedge clk);
    bus.flush             = f;
    bus.alloc_req         = req;
    bus.retire_valid      = rv;
    bus.retire_has_rd     = rhr;
    bus.rd_phy_old_commit = phy_tag_t'(old);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.flush         = 1'b0;
    bus.alloc_req     = 2'b00;
    bus.retire_valid  = 1'b0;
    bus.retire_has_rd = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.flush             = 1'b0;
    bus.alloc_req         = 2'b00;
    bus.retire_valid      = 1'b0;
    bus.retire_has_rd     = 1'b0;
    bus.rd_phy_old_commit = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    apply(0, 2'b00, 0, 0, 0);
    push("count", 32); push("ovf", 0); push("phy0", 32); push("grant", 1);
    drain();

    // drain the list with 16 pair allocations
    for (int k = 0; k < 16; k++) begin
      apply(0, 2'b11, 0, 0, 0);
      push("phy0", 32 + 2*k); push("phy1", 33 + 2*k);
      push("grant", 1); push("count", 32 - 2*k);
      drain();
    end
    apply(0, 2'b01, 0, 0, 0);
    push("grant", 0); push("count", 0); push("phy0", 32);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("phy0", 32); push("count", 0); push("grant", 1);
    drain();

    // free into the empty list, wrapping the tail index to 0
    apply(0, 2'b00, 1, 1, 5);
    push("count", 0);
    drain();
    apply(0, 2'b11, 0, 0, 0);
    push("count", 1); push("grant", 0);
    drain();
    apply(0, 2'b10, 0, 0, 0);
    push("grant", 1); push("phy1", 5); push("phy0", 5);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("count", 0);
    drain();

    // speculative allocations rolled back by flush
    do_reset();
    apply(0, 2'b11, 0, 0, 0);
    push("phy0", 32); push("phy1", 33);
    drain();
    apply(0, 2'b11, 0, 0, 0);
    push("phy0", 34); push("phy1", 35); push("count", 30);
    drain();
    apply(0, 2'b00, 1, 1, 3);
    push("count", 28);
    drain();
    apply(1, 2'b11, 0, 0, 0);
    push("grant", 0); push("count", 29);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("count", 32); push("ovf", 0);
    drain();
    apply(0, 2'b11, 0, 0, 0);
    push("phy0", 33); push("phy1", 34); push("grant", 1);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("count", 30);
    drain();

    // flush together with a retire: head takes the advanced commit head
    do_reset();
    apply(0, 2'b11, 0, 0, 0);
    push("phy0", 32);
    drain();
    apply(1, 2'b00, 1, 1, 9);
    push("count", 30);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("count", 32); push("phy0", 33);
    drain();

    // free into a full list alongside an allocation
    do_reset();
    apply(0, 2'b11, 1, 1, 7);
    push("grant", 1); push("phy0", 32); push("phy1", 33);
    push("ovf", 0); push("count", 32);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("ovf", 1); push("count", 30); push("phy0", 34);
    drain();
    apply(0, 2'b00, 1, 0, 9);
    push("count", 30);
    drain();
    apply(0, 2'b00, 0, 0, 0);
    push("count", 30); push("ovf", 1);
    drain();

    // asynchronous reset mid-stream after 10 more allocations
    for (int k = 0; k < 5; k++) begin
      apply(0, 2'b11, 0, 0, 0);
      push("phy0", 34 + 2*k);
      drain();
    end
    apply(0, 2'b00, 0, 0, 0);
    push("count", 20); push("ovf", 1);
    drain();
    @(negedge clk);
    rst = 1'b1;
    #1;
    push("count", 32); push("ovf", 0); push("phy0", 32);
    drain();
    @(negedge clk);
    rst = 1'b0;
    apply(0, 2'b00, 0, 0, 0);
    push("count", 32); push("phy0", 32); push("ovf", 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
